// File: rtl/systolic_matmul_cfg_pkg.sv
// Shared types and helpers for the configurable systolic matrix multiplier:
// FSM states, latency/width helpers and the result formatting function.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        FORMAT,
        DONE
    } state_t;

    // Widest accumulator / result the formatting function can handle.
    localparam int unsigned MAX_ACC_W = 64;
    localparam int unsigned MAX_OUT_W = 32;

    typedef struct packed {
        logic [MAX_OUT_W-1:0] res;
        logic                 ovf;
    } fmt_t;

    function automatic int unsigned lat(input int unsigned m, input int unsigned n,
                                        input int unsigned p);
        return n + m + p - 1;
    endfunction

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
        return 2 * dw + $clog2(n) + 2;
    endfunction

    function automatic fmt_t format_elem(input logic signed [MAX_ACC_W-1:0] v,
                                         input logic sgn, input logic sat,
                                         input int unsigned w);
        logic signed [MAX_ACC_W-1:0] lo;
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] r;
        fmt_t f;
        if (sgn) begin
            hi = (64'sd1 <<< (w - 1)) - 64'sd1;
            lo = -hi - 64'sd1;
        end else begin
            lo = '0;
            hi = (64'sd1 <<< w) - 64'sd1;
        end
        f.ovf = (v < lo) || (v > hi);
        r = v;
        if (sat && (v < lo)) r = lo;
        else if (sat && (v > hi)) r = hi;
        f.res = r[MAX_OUT_W-1:0];
        return f;
    endfunction

endpackage

// File: rtl/systolic_matmul_cfg_pe.sv
// Output-stationary processing element: forwards A right and B down one
// register per cycle and accumulates the valid-gated signed product.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int unsigned OP_WIDTH  = 9,
    parameter int unsigned ACC_WIDTH = 21
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic                        en_i,
    input  logic signed [OP_WIDTH-1:0]  a_i,
    input  logic signed [OP_WIDTH-1:0]  b_i,
    input  logic                        a_v_i,
    input  logic                        b_v_i,
    output logic signed [OP_WIDTH-1:0]  a_o,
    output logic signed [OP_WIDTH-1:0]  b_o,
    output logic                        a_v_o,
    output logic                        b_v_o,
    output logic signed [ACC_WIDTH-1:0] acc_o
);

    logic signed [OP_WIDTH-1:0]   a_q, b_q;
    logic                         a_v_q, b_v_q;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [2*OP_WIDTH-1:0] prod;

    assign prod = (2*OP_WIDTH)'(a_i) * (2*OP_WIDTH)'(b_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i && a_v_i && b_v_i) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            a_v_q <= 1'b0;
            b_v_q <= 1'b0;
            acc_q <= '0;
        end else begin
            if (clr_i) begin
                a_q   <= '0;
                b_q   <= '0;
                a_v_q <= 1'b0;
                b_v_q <= 1'b0;
            end else begin
                a_q   <= a_i;
                b_q   <= b_i;
                a_v_q <= a_v_i;
                b_v_q <= b_v_i;
            end
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign a_v_o = a_v_q;
    assign b_v_o = b_v_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_matmul_cfg.sv
// Configurable C = A x B on an MxP output-stationary PE array with skewed
// edge feeds, signed/unsigned operands and wrap/saturate result formatting.
module systolic_matmul_cfg
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned M          = 8,
    parameter int unsigned N          = 8,
    parameter int unsigned P          = 8,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, N)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         signed_en,
    input  logic                         sat_en,
    input  logic [M*N*DATA_WIDTH-1:0]    matrix_a,
    input  logic [N*P*DATA_WIDTH-1:0]    matrix_b,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [M*P*OUT_WIDTH-1:0]     result_c
);

    localparam int unsigned OPW       = DATA_WIDTH + 1;
    localparam int unsigned LAST_STEP = lat(M, N, P) - 2;
    localparam int unsigned SW        = $clog2(LAST_STEP + 1) + 1;

    state_t                  state_q, state_d;
    logic [SW-1:0]           step_q, step_d;
    logic                    accept;
    logic                    compute_en;
    logic                    sgn_q, sat_q;
    logic [DATA_WIDTH-1:0]   a_q [M][N];
    logic [DATA_WIDTH-1:0]   b_q [N][P];
    logic [OUT_WIDTH-1:0]    res_q [M][P];
    logic [OUT_WIDTH-1:0]    res_d [M][P];
    logic                    ovf_q, ovf_d;
    fmt_t                    fmt_v;

    logic signed [OPW-1:0]       a_feed [M];
    logic                        a_fv   [M];
    logic signed [OPW-1:0]       b_feed [P];
    logic                        b_fv   [P];
    logic signed [OPW-1:0]       a_out  [M][P];
    logic                        av_out [M][P];
    logic signed [OPW-1:0]       b_out  [M][P];
    logic                        bv_out [M][P];
    logic signed [ACC_WIDTH-1:0] acc_out [M][P];
    logic                        unused_edge;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = COMPUTE;
                    step_d  = '0;
                end
            end
            COMPUTE: begin
                if (step_q == SW'(LAST_STEP)) state_d = FORMAT;
                else                          step_d  = step_q + 1'b1;
            end
            FORMAT:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            sgn_q   <= 1'b0;
            sat_q   <= 1'b0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            res_q   <= '{default: '0};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (accept) begin
                sgn_q <= signed_en;
                sat_q <= sat_en;
                for (int unsigned i = 0; i < M; i++)
                    for (int unsigned k = 0; k < N; k++)
                        a_q[i][k] <= matrix_a[(i*N+k)*DATA_WIDTH +: DATA_WIDTH];
                for (int unsigned k = 0; k < N; k++)
                    for (int unsigned j = 0; j < P; j++)
                        b_q[k][j] <= matrix_b[(k*P+j)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state_q == FORMAT) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign compute_en = (state_q == COMPUTE);

    // Row i is fed a(i, t-i) and column j is fed b(t-j, j); the PE
    // forwarding registers then supply k = t-i-j everywhere in the array.
    always_comb begin
        for (int unsigned i = 0; i < M; i++) begin
            a_feed[i] = '0;
            a_fv[i]   = 1'b0;
            if (compute_en) begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (32'(step_q) == i + k) begin
                        a_fv[i]   = 1'b1;
                        a_feed[i] = {sgn_q & a_q[i][k][DATA_WIDTH-1], a_q[i][k]};
                    end
                end
            end
        end
        for (int unsigned j = 0; j < P; j++) begin
            b_feed[j] = '0;
            b_fv[j]   = 1'b0;
            if (compute_en) begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (32'(step_q) == j + k) begin
                        b_fv[j]   = 1'b1;
                        b_feed[j] = {sgn_q & b_q[k][j][DATA_WIDTH-1], b_q[k][j]};
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < P; j++) begin : g_col
            logic signed [OPW-1:0] a_in, b_in;
            logic                  av_in, bv_in;

            if (j == 0) begin : g_a_edge
                assign a_in  = a_feed[i];
                assign av_in = a_fv[i];
            end else begin : g_a_fwd
                assign a_in  = a_out[i][j-1];
                assign av_in = av_out[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in  = b_feed[j];
                assign bv_in = b_fv[j];
            end else begin : g_b_fwd
                assign b_in  = b_out[i-1][j];
                assign bv_in = bv_out[i-1][j];
            end

            systolic_pe #(
                .OP_WIDTH  (OPW),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .clr_i (accept),
                .en_i  (compute_en),
                .a_i   (a_in),
                .b_i   (b_in),
                .a_v_i (av_in),
                .b_v_i (bv_in),
                .a_o   (a_out[i][j]),
                .b_o   (b_out[i][j]),
                .a_v_o (av_out[i][j]),
                .b_v_o (bv_out[i][j]),
                .acc_o (acc_out[i][j])
            );
        end
    end

    always_comb begin
        unused_edge = 1'b0;
        for (int unsigned i = 0; i < M; i++)
            unused_edge = unused_edge ^ (^{a_out[i][P-1], av_out[i][P-1]});
        for (int unsigned j = 0; j < P; j++)
            unused_edge = unused_edge ^ (^{b_out[M-1][j], bv_out[M-1][j]});
    end

    always_comb begin
        ovf_d = 1'b0;
        fmt_v = '0;
        res_d = '{default: '0};
        for (int unsigned i = 0; i < M; i++) begin
            for (int unsigned j = 0; j < P; j++) begin
                fmt_v       = format_elem(MAX_ACC_W'(acc_out[i][j]), sgn_q, sat_q, OUT_WIDTH);
                res_d[i][j] = fmt_v.res[OUT_WIDTH-1:0];
                ovf_d       = ovf_d | fmt_v.ovf;
            end
        end
    end

    always_comb begin
        result_c = '0;
        for (int unsigned i = 0; i < M; i++)
            for (int unsigned j = 0; j < P; j++)
                result_c[(i*P+j)*OUT_WIDTH +: OUT_WIDTH] = res_q[i][j];
    end

    assign busy     = (state_q == COMPUTE) || (state_q == FORMAT);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_systolic_matmul_cfg.sv
// Directed/random bench for systolic_matmul_cfg against an arithmetic
// reference of the matrix product and the wrap/saturate rules.
module tb_systolic_matmul_cfg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8x8x8 instance
    logic         start1, sg1, sat1;
    logic [511:0] ma1, mb1;
    logic         busy1, done1, ovf1;
    logic [511:0] rc1;

    // 4x6x3, 16-bit instance
    logic         start2, sg2, sat2;
    logic [383:0] ma2;
    logic [287:0] mb2;
    logic         busy2, done2, ovf2;
    logic [191:0] rc2;

    int checks = 0;
    int passed = 0;

    systolic_matmul_cfg #(
        .DATA_WIDTH (8), .M (8), .N (8), .P (8), .OUT_WIDTH (8)
    ) u_dut1 (
        .clk (clk), .rst_n (rst_n), .start (start1), .signed_en (sg1), .sat_en (sat1),
        .matrix_a (ma1), .matrix_b (mb1), .busy (busy1), .done (done1),
        .overflow (ovf1), .result_c (rc1)
    );

    systolic_matmul_cfg #(
        .DATA_WIDTH (16), .M (4), .N (6), .P (3), .OUT_WIDTH (16)
    ) u_dut2 (
        .clk (clk), .rst_n (rst_n), .start (start2), .signed_en (sg2), .sat_en (sat2),
        .matrix_a (ma2), .matrix_b (mb2), .busy (busy2), .done (done2),
        .overflow (ovf2), .result_c (rc2)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic longint elem(input logic [511:0] v, input int off, input int w,
                                    input bit sg);
        logic [63:0] t;
        t = 64'(v >> off) & ((64'd1 << w) - 64'd1);
        if (sg && t[w-1]) return longint'(t) - (longint'(1) <<< w);
        return longint'(t);
    endfunction

    function automatic void model(input logic [511:0] av, input logic [511:0] bv,
                                  input int m, input int n, input int p,
                                  input int dw, input int ow, input bit sg, input bit sat,
                                  output logic [511:0] c, output logic ovf);
        longint s, lo, hi, r;
        c   = '0;
        ovf = 1'b0;
        if (sg) begin
            lo = -(longint'(1) <<< (ow - 1));
            hi = (longint'(1) <<< (ow - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) <<< ow) - 1;
        end
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < p; j++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += elem(av, (i*n+k)*dw, dw, sg) * elem(bv, (k*p+j)*dw, dw, sg);
                if (s < lo || s > hi) ovf = 1'b1;
                r = s;
                if (sat) r = (s < lo) ? lo : ((s > hi) ? hi : s);
                c |= 512'(r & ((longint'(1) <<< ow) - 1)) << ((i*p+j)*ow);
            end
        end
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic launch1(input logic [511:0] a, input logic [511:0] b, input bit sg,
                           input bit sat);
        ma1 = a; mb1 = b; sg1 = sg; sat1 = sat; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    task automatic wait_done1(output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done1) begin
                cyc = c;
                break;
            end
            if (!busy1) busy_ok = 1'b0;
        end
    endtask

    task automatic wait_done2(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done2) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic run1(input string tag, input logic [511:0] a, input logic [511:0] b,
                        input bit sg, input bit sat);
        logic [511:0] ec;
        logic         eo;
        int           cyc;
        bit           bok;
        model(a, b, 8, 8, 8, 8, 8, sg, sat, ec, eo);
        launch1(a, b, sg, sat);
        wait_done1(cyc, bok);
        chk({tag, "_latency"}, 512'(cyc), 512'(23));
        chk({tag, "_busy"}, 512'(bok), 512'(1));
        chk({tag, "_result"}, rc1, ec);
        chk({tag, "_ovf"}, 512'(ovf1), 512'(eo));
    endtask

    initial begin
        logic [511:0] a, b, ec, ec2, x1a, x1b, x2a, x2b, keep;
        logic         eo, eo2;
        int           cyc;
        bit           bok;

        rst_n = 1'b0;
        start1 = 1'b0; sg1 = 1'b0; sat1 = 1'b0; ma1 = '0; mb1 = '0;
        start2 = 1'b0; sg2 = 1'b0; sat2 = 1'b0; ma2 = '0; mb2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 512'(busy1), 512'(0));
        chk("reset_done", 512'(done1), 512'(0));
        chk("reset_ovf", 512'(ovf1), 512'(0));
        chk("reset_result", rc1, 512'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // identity times B
        a = '0;
        b = '0;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                a[(i*8+k)*8 +: 8] = (i == k) ? 8'd1 : 8'd0;
                b[(i*8+k)*8 +: 8] = 8'(i*8 + k);
            end
        run1("ident", a, b, 1'b1, 1'b1);
        chk("ident_eq_b", rc1, b);
        keep = rc1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", 512'(done1), 512'(1));
        chk("result_hold", rc1, keep);

        // 0x7F everywhere: saturate and wrap
        run1("max_sat", {64{8'h7f}}, {64{8'h7f}}, 1'b1, 1'b1);
        chk("max_sat_const", rc1, {64{8'h7f}});
        run1("max_wrap", {64{8'h7f}}, {64{8'h7f}}, 1'b1, 1'b0);
        chk("max_wrap_const", rc1, {64{8'h08}});

        // 0xFF x 0x01 in three modes
        run1("neg_s_sat", {64{8'hff}}, {64{8'h01}}, 1'b1, 1'b1);
        chk("neg_s_sat_const", rc1, {64{8'hf8}});
        run1("neg_u_sat", {64{8'hff}}, {64{8'h01}}, 1'b0, 1'b1);
        run1("neg_u_wrap", {64{8'hff}}, {64{8'h01}}, 1'b0, 1'b0);

        // second start and operand change mid-run are ignored
        a = rnd512();
        b = rnd512();
        model(a, b, 8, 8, 8, 8, 8, 1'b1, 1'b1, ec, eo);
        launch1(a, b, 1'b1, 1'b1);
        cyc = 0;
        bok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done1) begin
                cyc = c;
                break;
            end
            if (!busy1) bok = 1'b0;
            if (c == 5) begin
                start1 = 1'b1;
                ma1 = ~ma1;
                sat1 = 1'b0;
            end
            if (c == 6) start1 = 1'b0;
        end
        chk("restart_latency", 512'(cyc), 512'(23));
        chk("restart_busy", 512'(bok), 512'(1));
        chk("restart_result", rc1, ec);
        chk("restart_ovf", 512'(ovf1), 512'(eo));

        // asynchronous reset mid-compute
        launch1(rnd512(), rnd512(), 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset_busy", 512'(busy1), 512'(0));
        chk("areset_done", 512'(done1), 512'(0));
        chk("areset_ovf", 512'(ovf1), 512'(0));
        chk("areset_result", rc1, 512'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run1("post_reset", rnd512(), rnd512(), 1'b1, 1'b0);
        run1("rand_u", rnd512(), rnd512(), 1'b0, 1'b1);

        // 4x6x3, 16-bit, start held across two runs
        x1a = rnd512(); x1b = rnd512(); x2a = rnd512(); x2b = rnd512();
        x1a[511:384] = '0; x2a[511:384] = '0;
        x1b[511:288] = '0; x2b[511:288] = '0;
        model(x1a, x1b, 4, 6, 3, 16, 16, 1'b1, 1'b0, ec, eo);
        model(x2a, x2b, 4, 6, 3, 16, 16, 1'b0, 1'b1, ec2, eo2);
        ma2 = x1a[383:0]; mb2 = x1b[287:0]; sg2 = 1'b1; sat2 = 1'b0;
        start2 = 1'b1;
        @(posedge clk); #1;
        chk("p2_accept_busy", 512'(busy2), 512'(1));
        ma2 = x2a[383:0]; mb2 = x2b[287:0]; sg2 = 1'b0; sat2 = 1'b1;
        wait_done2(cyc);
        chk("p2_run1_latency", 512'(cyc), 512'(12));
        chk("p2_run1_result", 512'(rc2), ec);
        chk("p2_run1_ovf", 512'(ovf2), 512'(eo));
        @(posedge clk); #1;
        chk("p2_b2b_busy", 512'(busy2), 512'(1));
        chk("p2_b2b_done", 512'(done2), 512'(0));
        chk("p2_b2b_result_kept", 512'(rc2), ec);
        wait_done2(cyc);
        start2 = 1'b0;
        chk("p2_run2_latency", 512'(cyc), 512'(12));
        chk("p2_run2_result", 512'(rc2), ec2);
        chk("p2_run2_ovf", 512'(ovf2), 512'(eo2));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
